// File: rtl/conv_sequencer.sv
// conv_sequencer: walks one shared MAC datapath over every filter, output position and kernel tap,
// issuing buffer addresses plus accumulator and write-back strobes.
module conv_sequencer #(
  parameter int DATA_X = 28,
  parameter int DATA_Y = 28,
  parameter int WEIGHT_X = 5,
  parameter int WEIGHT_Y = 5,
  parameter int NUM_FILTERS = 8,
  localparam int CONV_X = DATA_X - WEIGHT_X + 1,
  localparam int CONV_Y = DATA_Y - WEIGHT_Y + 1,
  localparam int TAPS = WEIGHT_X * WEIGHT_Y,
  localparam int DXW = $clog2(DATA_X),
  localparam int DYW = $clog2(DATA_Y),
  localparam int FW = $clog2(NUM_FILTERS),
  localparam int WIW = $clog2(WEIGHT_X),
  localparam int WJW = $clog2(WEIGHT_Y),
  localparam int CXW = $clog2(CONV_X),
  localparam int CYW = $clog2(CONV_Y)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           stall,
  output logic           busy,
  output logic           done,
  output logic [DXW-1:0] data_x,
  output logic [DYW-1:0] data_y,
  output logic [FW-1:0]  filt,
  output logic [WIW-1:0] w_i,
  output logic [WJW-1:0] w_j,
  output logic           mac_clear,
  output logic           mac_en,
  output logic           wr_en,
  output logic [CXW-1:0] wr_x,
  output logic [CYW-1:0] wr_y
);
  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;
  localparam logic [WIW-1:0] I_LAST = WIW'(WEIGHT_X - 1);
  localparam logic [WJW-1:0] J_LAST = WJW'(WEIGHT_Y - 1);
  localparam logic [CXW-1:0] X_LAST = CXW'(CONV_X - 1);
  localparam logic [CYW-1:0] Y_LAST = CYW'(CONV_Y - 1);
  localparam logic [FW-1:0]  F_LAST = FW'(NUM_FILTERS - 1);
  state_t state_q, state_d;
  logic [FW-1:0]  f_q, f_d;
  logic [CXW-1:0] x_q, x_d;
  logic [CYW-1:0] y_q, y_d;
  logic [WIW-1:0] i_q, i_d;
  logic [WJW-1:0] j_q, j_d;
  logic x_last, y_last, f_last;
  assign x_last = x_q == X_LAST;
  assign y_last = y_q == Y_LAST;
  assign f_last = f_q == F_LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      f_q <= '0;
      x_q <= '0;
      y_q <= '0;
      i_q <= '0;
      j_q <= '0;
    end else begin
      state_q <= state_d;
      f_q <= f_d;
      x_q <= x_d;
      y_q <= y_d;
      i_q <= i_d;
      j_q <= j_d;
    end
  end
  // every counter wraps to zero on its last value, so the final write leaves all counters cleared for DONE
  always_comb begin
    state_d = state_q;
    f_d = f_q;
    x_d = x_q;
    y_d = y_q;
    i_d = i_q;
    j_d = j_q;
    case (state_q)
      IDLE: state_d = start ? MAC : IDLE;
      MAC: if (!stall) begin
        j_d = (j_q == J_LAST) ? '0 : j_q + 1'b1;
        i_d = (j_q != J_LAST) ? i_q : (i_q == I_LAST) ? '0 : i_q + 1'b1;
        state_d = (j_q == J_LAST && i_q == I_LAST) ? WRITE : MAC;
      end
      WRITE: if (!stall) begin
        y_d = y_last ? '0 : y_q + 1'b1;
        x_d = !y_last ? x_q : x_last ? '0 : x_q + 1'b1;
        f_d = !(y_last && x_last) ? f_q : f_last ? '0 : f_q + 1'b1;
        state_d = (y_last && x_last && f_last) ? DONE : MAC;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign mac_en = state_q == MAC && !stall;
  assign mac_clear = mac_en && i_q == '0 && j_q == '0;
  assign wr_en = state_q == WRITE && !stall;
  assign data_x = DXW'(x_q) + DXW'(i_q);
  assign data_y = DYW'(y_q) + DYW'(j_q);
  assign filt = f_q;
  assign w_i = i_q;
  assign w_j = j_q;
  assign wr_x = x_q;
  assign wr_y = y_q;
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: randomized-stall scoreboard plus directed timing scenarios for conv_sequencer
// on a reduced, non-square geometry so several full passes fit in a short run.
module tb_conv_sequencer;
  localparam int DX = 10, DY = 12, WX = 3, WY = 4, NF = 3;
  localparam int CX = DX - WX + 1, CY = DY - WY + 1, TAPS = WX * WY;
  localparam int NOUT = NF * CX * CY, N = NOUT * (TAPS + 1);
  localparam int DXW = $clog2(DX), DYW = $clog2(DY), FW = $clog2(NF);
  localparam int WIW = $clog2(WX), WJW = $clog2(WY), CXW = $clog2(CX), CYW = $clog2(CY);

  typedef struct packed {
    logic busy, done, mac_en, mac_clear, wr_en;
    logic [FW-1:0] filt;
    logic [DXW-1:0] dx;
    logic [DYW-1:0] dy;
    logic [WIW-1:0] wi;
    logic [WJW-1:0] wj;
    logic [CXW-1:0] wx;
    logic [CYW-1:0] wy;
  } out_t;

  logic clk = 0, rst = 1, start = 0, stall = 0;
  logic busy, done, mac_clear, mac_en, wr_en;
  logic [DXW-1:0] data_x;
  logic [DYW-1:0] data_y;
  logic [FW-1:0] filt;
  logic [WIW-1:0] w_i;
  logic [WJW-1:0] w_j;
  logic [CXW-1:0] wr_x;
  logic [CYW-1:0] wr_y;
  out_t act, first_tap;
  out_t exp_q[$];
  int kind_q[$];
  int total = 0, bad = 0;

  conv_sequencer #(.DATA_X(DX), .DATA_Y(DY), .WEIGHT_X(WX), .WEIGHT_Y(WY), .NUM_FILTERS(NF)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy), .done(done),
    .data_x(data_x), .data_y(data_y), .filt(filt), .w_i(w_i), .w_j(w_j),
    .mac_clear(mac_clear), .mac_en(mac_en), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y)
  );

  always #5 clk = ~clk;
  assign act = {busy, done, mac_en, mac_clear, wr_en, filt, data_x, data_y, w_i, w_j, wr_x, wr_y};

  initial begin
    first_tap = '0;
    first_tap.busy = 1;
    first_tap.mac_en = 1;
    first_tap.mac_clear = 1;
  end

  // expected unstalled output sequence of one pass, straight from the loop nest filt,x,y,i,j
  task automatic build_model();
    out_t e;
    exp_q.delete();
    kind_q.delete();
    for (int f = 0; f < NF; f++)
      for (int x = 0; x < CX; x++)
        for (int y = 0; y < CY; y++) begin
          for (int i = 0; i < WX; i++)
            for (int j = 0; j < WY; j++) begin
              e = '0;
              e.busy = 1; e.mac_en = 1; e.mac_clear = (i == 0 && j == 0);
              e.filt = FW'(f); e.dx = DXW'(x + i); e.dy = DYW'(y + j);
              e.wi = WIW'(i); e.wj = WJW'(j); e.wx = CXW'(x); e.wy = CYW'(y);
              exp_q.push_back(e); kind_q.push_back(0);
            end
          e = '0;
          e.busy = 1; e.wr_en = 1; e.filt = FW'(f);
          e.dx = DXW'(x); e.dy = DYW'(y); e.wx = CXW'(x); e.wy = CYW'(y);
          exp_q.push_back(e); kind_q.push_back(1);
        end
    e = '0;
    e.busy = 1; e.done = 1;
    exp_q.push_back(e); kind_q.push_back(2);
  endtask

  task automatic test_reset();
    rst = 1; start = 0; stall = 1;
    repeat (3) @(negedge clk);
    #1; total++;
    if (act !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", act); end
    @(negedge clk); rst = 0; stall = 0;
    @(negedge clk); #1; total++;
    if (act !== '0) begin bad++; $display("FAIL idle_after_reset: got %h want 0", act); end
  endtask

  task automatic test_clean_pass();
    int sweep_c;
    sweep_c = ((1 * CX + 5) * CY + 7) * (TAPS + 1) + (2 * WY + 3) + 1;
    @(negedge clk); start = 1; stall = 0;
    for (int c = 1; c <= N + 2; c++) begin
      @(negedge clk); start = 0; #1;
      if (c == 1) begin
        total++;
        if (act !== first_tap) begin bad++; $display("FAIL first_tap: got %h want %h", act, first_tap); end
      end
      if (c == TAPS + 1) begin
        total++;
        if ({wr_en, mac_en, wr_x, wr_y, filt} !== {1'b1, 1'b0, CXW'(0), CYW'(0), FW'(0)}) begin
          bad++; $display("FAIL first_write: got wr_en=%b mac_en=%b x=%0d y=%0d f=%0d", wr_en, mac_en, wr_x, wr_y, filt);
        end
      end
      if (c == sweep_c) begin
        total++;
        if ({mac_en, data_x, data_y, filt} !== {1'b1, DXW'(7), DYW'(10), FW'(1)}) begin
          bad++; $display("FAIL sweep_addr: got en=%b dx=%0d dy=%0d f=%0d want 1 7 10 1", mac_en, data_x, data_y, filt);
        end
      end
      if (c == N - 1) begin
        total++;
        if ({mac_en, data_x, data_y} !== {1'b1, DXW'(DX - 1), DYW'(DY - 1)}) begin
          bad++; $display("FAIL last_tap_addr: got en=%b dx=%0d dy=%0d", mac_en, data_x, data_y);
        end
      end
      if (c == N + 1) begin
        total++;
        if ({busy, done, wr_en, mac_en} !== 4'b1100) begin
          bad++; $display("FAIL done_cycle: got busy=%b done=%b wr=%b mac=%b want 1100", busy, done, wr_en, mac_en);
        end
      end
      if (c == N + 2) begin
        total++;
        if (act !== '0) begin bad++; $display("FAIL idle_after_done: got %h want 0", act); end
      end
    end
  endtask

  task automatic test_random_stall();
    out_t e;
    int cyc;
    build_model();
    @(negedge clk); start = 1; stall = 0;
    @(negedge clk); start = 0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 3 * N) begin
      stall = ($urandom_range(0, 99) < 30);
      #1;
      e = exp_q[0];
      if (stall && kind_q[0] != 2) begin
        e.mac_en = 0; e.mac_clear = 0; e.wr_en = 0;
      end else begin
        void'(exp_q.pop_front());
        void'(kind_q.pop_front());
      end
      total++;
      if (act !== e) begin bad++; $display("FAIL scoreboard cyc=%0d stall=%b: got %h want %h", cyc, stall, act, e); end
      cyc++;
      @(negedge clk);
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_budget: %0d items left want 0", exp_q.size()); end
    stall = 1; #1; total++;
    if (act !== '0) begin bad++; $display("FAIL idle_after_random: got %h want 0", act); end
    stall = 0;
  endtask

  task automatic test_stall_timing();
    int ti, nw, st_t, st_w, first_wr, done_c, ndone, last_c;
    ti = 0; nw = 0; st_t = 0; st_w = 0; first_wr = 0; done_c = 0; ndone = 0; last_c = 0;
    @(negedge clk); start = 1; stall = 0;
    @(negedge clk); start = 0;
    for (int c = 1; c <= N + 50; c++) begin
      stall = (ti == 10 && st_t < 3) || (ti == TAPS && nw == 0 && st_w < 2);
      #1;
      last_c = c;
      if (stall && ti == 10) begin
        st_t++; total++;
        if ({mac_en, mac_clear, w_i, w_j, data_x, data_y} !== {2'b00, WIW'(2), WJW'(2), DXW'(2), DYW'(2)}) begin
          bad++; $display("FAIL stalled_tap_hold: got en=%b i=%0d j=%0d dx=%0d dy=%0d", mac_en, w_i, w_j, data_x, data_y);
        end
      end
      if (stall && ti == TAPS) begin
        st_w++; total++;
        if ({wr_en, busy, wr_x, wr_y} !== {2'b01, CXW'(0), CYW'(0)}) begin
          bad++; $display("FAIL stalled_write_hold: got wr=%b busy=%b x=%0d y=%0d", wr_en, busy, wr_x, wr_y);
        end
      end
      if (mac_en) ti++;
      if (wr_en) begin nw++; if (first_wr == 0) first_wr = c; end
      if (done) begin ndone++; done_c = c; end
      if (!busy) break;
      @(negedge clk);
    end
    stall = 0;
    total++;
    if (ti != NOUT * TAPS) begin bad++; $display("FAIL tap_count: got %0d want %0d", ti, NOUT * TAPS); end
    total++;
    if (nw != NOUT) begin bad++; $display("FAIL write_count: got %0d want %0d", nw, NOUT); end
    total++;
    if (first_wr != TAPS + 1 + 5) begin bad++; $display("FAIL stalled_first_write: got %0d want %0d", first_wr, TAPS + 6); end
    total++;
    if (done_c != N + 1 + 5 || ndone != 1) begin bad++; $display("FAIL stalled_done: got cycle %0d x%0d want %0d x1", done_c, ndone, N + 6); end
    total++;
    if (last_c != N + 2 + 5) begin bad++; $display("FAIL stalled_idle: got %0d want %0d", last_c, N + 7); end
  endtask

  task automatic test_start_held();
    int ndone;
    ndone = 0;
    @(negedge clk); start = 1; stall = 0;
    for (int c = 1; c <= N + 3; c++) begin
      @(negedge clk); #1;
      if (done) ndone++;
      if (c == N + 1) begin
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL held_done: got %b want 1", done); end
      end
      if (c == N + 2) begin
        total++;
        if ({busy, done, mac_en} !== 3'b000) begin bad++; $display("FAIL held_idle: got busy=%b done=%b en=%b want 000", busy, done, mac_en); end
      end
      if (c == N + 3) begin
        total++;
        if (act !== first_tap) begin bad++; $display("FAIL held_restart: got %h want %h", act, first_tap); end
      end
    end
    total++;
    if (ndone != 1) begin bad++; $display("FAIL held_one_pass: got %0d done pulses want 1", ndone); end
    start = 0; rst = 1;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_mid_reset();
    int ndone;
    ndone = 0;
    @(negedge clk); start = 1; stall = 0;
    @(negedge clk); start = 0;
    repeat (500) begin
      stall = ($urandom_range(0, 99) < 20);
      #1;
      if (done) ndone++;
      @(negedge clk);
    end
    stall = 1; rst = 1;
    @(negedge clk); #1;
    if (done) ndone++;
    total++;
    if (act !== '0) begin bad++; $display("FAIL mid_reset_outputs: got %h want 0", act); end
    rst = 0; stall = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (done) ndone++;
      total++;
      if (act !== '0) begin bad++; $display("FAIL mid_reset_idle: got %h want 0", act); end
    end
    total++;
    if (ndone != 0) begin bad++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", ndone); end
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; #1;
    total++;
    if (act !== first_tap) begin bad++; $display("FAIL restart_after_reset: got %h want %h", act, first_tap); end
  endtask

  task automatic test_stalled_start();
    out_t e;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    @(negedge clk); start = 1; stall = 1;
    @(negedge clk); start = 0; #1;
    e = '0; e.busy = 1;
    total++;
    if (act !== e) begin bad++; $display("FAIL stalled_first_tap: got %h want %h", act, e); end
    stall = 0; #1;
    total++;
    if (act !== first_tap) begin bad++; $display("FAIL released_first_tap: got %h want %h", act, first_tap); end
    @(negedge clk); #1;
    e = first_tap; e.mac_clear = 0; e.dy = 1; e.wj = 1;
    total++;
    if (act !== e) begin bad++; $display("FAIL second_tap: got %h want %h", act, e); end
    rst = 1;
    @(negedge clk); rst = 0;
  endtask

  initial begin
    test_reset();
    test_clean_pass();
    test_random_stall();
    test_stall_timing();
    test_start_held();
    test_mid_reset();
    test_stalled_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
